// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver (data width, parity, stop bits) with start-glitch
// rejection, per-word error flags and a show-ahead receive FIFO.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 40_000_000,
  parameter int UART_BPS   = 128000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 clr_err,
  output logic                 rx_busy
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = DATA_BITS + 2;
  localparam logic [CW-1:0] CNT_MAX   = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(BPS_CNT / 2);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;
  logic                   ovr_q, ovr_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          mem_d [FIFO_DEPTH];

  logic          rxd_s, start_edge, mid, wrap, push, pop, full, empty, ferr_now;
  logic [EW-1:0] head;

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], uart_rxd};
    rxd_s     = sync_q[1];
    prev_d    = rxd_s;
    clk_cnt_d = (clk_cnt_q == CNT_MAX) ? '0 : clk_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ferr_now  = ferr_q;
    push      = 1'b0;

    start_edge = prev_q & ~rxd_s;
    mid        = (clk_cnt_q == CNT_MID);
    wrap       = (clk_cnt_q == CNT_MAX);

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_START;
          bit_idx_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: begin
        if (mid && rxd_s) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (mid) shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (mid) perr_d = (PARITY == 1) ? ~(^shift_q ^ rxd_s) : (^shift_q ^ rxd_s);
        if (wrap) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        if (mid) begin
          ferr_now = ferr_q | ~rxd_s;
          ferr_d   = ferr_now;
          // Push on the last stop sample so the next start edge has half a bit of slack.
          if (bit_idx_q == LAST_STOP) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
        if (wrap) bit_idx_d = bit_idx_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || state_d == S_IDLE) clk_cnt_d = '0;
    busy_d = (state_d != S_IDLE);
  end

  // Consumer handshake: rx_valid is high while an entry is held; the head entry
  // is consumed on any clock edge where rx_valid and rx_ready are both high.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rx_valid = ~empty;
    pop      = rx_valid & rx_ready;
    head     = mem_q[rd_ptr_q[AW-1:0]];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovr_d    = clr_err ? 1'b0 : ovr_q;
    if (push && (!full || pop)) begin
      mem_d[wr_ptr_q[AW-1:0]] = {ferr_now, perr_q, shift_q};
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (push && full && !pop) ovr_d = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
    rx_parity_err = rx_valid & head[DATA_BITS];
    rx_frame_err  = rx_valid & head[DATA_BITS+1];
    rx_overrun    = ovr_q;
    rx_busy       = busy_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default 8N1 instance plus even-parity and
// two-stop-bit instances running at 16 clocks per bit.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd   [3];
  logic       ready [3];
  logic       clr   [3];
  logic [7:0] data  [3];
  logic       pe    [3];
  logic       fe    [3];
  logic       vld   [3];
  logic       ovr   [3];
  logic       busy  [3];

  int         bps [3] = '{312, 16, 16};
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q [$];
  int         cyc;
  logic [7:0] cap_data;
  logic       cap_pe, cap_fe;

  always #5 clk = ~clk;

  uart_rx_fifo u_dflt (
    .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd[0]), .rx_data(data[0]),
    .rx_parity_err(pe[0]), .rx_frame_err(fe[0]), .rx_valid(vld[0]), .rx_ready(ready[0]),
    .rx_overrun(ovr[0]), .clr_err(clr[0]), .rx_busy(busy[0]));

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .PARITY(2)) u_par (
    .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd[1]), .rx_data(data[1]),
    .rx_parity_err(pe[1]), .rx_frame_err(fe[1]), .rx_valid(vld[1]), .rx_ready(ready[1]),
    .rx_overrun(ovr[1]), .clr_err(clr[1]), .rx_busy(busy[1]));

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .STOP_BITS(2)) u_stp (
    .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd[2]), .rx_data(data[2]),
    .rx_parity_err(pe[2]), .rx_frame_err(fe[2]), .rx_valid(vld[2]), .rx_ready(ready[2]),
    .rx_overrun(ovr[2]), .clr_err(clr[2]), .rx_busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int sel, input logic b);
    rxd[sel] = b;
    tick(bps[sel]);
  endtask

  // par < 0 means no parity bit is sent
  task automatic send_frame(input int sel, input logic [7:0] d, input int par,
                            input logic s1, input logic s2, input int nstop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (par >= 0) send_bit(sel, par[0]);
    send_bit(sel, s1);
    if (nstop == 2) send_bit(sel, s2);
    rxd[sel] = 1'b1;
  endtask

  task automatic pop_one(input int sel);
    ready[sel] = 1'b1;
    tick(1);
    ready[sel] = 1'b0;
  endtask

  task automatic check_head(input string tag, input int sel, input logic [7:0] d,
                            input logic p, input logic f);
    check({tag, "_valid"}, vld[sel], 1'b1);
    check({tag, "_data"},  data[sel], d);
    check({tag, "_perr"},  pe[sel], p);
    check({tag, "_ferr"},  fe[sel], f);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxd[i] = 1'b1; ready[i] = 1'b0; clr[i] = 1'b0;
    end
    tick(5);
    check("rst_valid", vld[0], 1'b0);
    check("rst_data",  data[0], 8'h00);
    check("rst_busy",  busy[0], 1'b0);
    check("rst_ovr",   ovr[0], 1'b0);
    check("rst_errs",  {pe[0], fe[0]}, 2'b00);
    rst = 1'b0;
    tick(10);

    // 8N1 0x55 with rx_ready held high: one-cycle valid pulse
    ready[0] = 1'b1;
    fork
      send_frame(0, 8'h55, -1, 1'b1, 1'b1, 1);
      begin
        cyc = 0;
        while (!vld[0] && cyc < 4000) begin
          @(negedge clk);
          cyc++;
        end
        cap_data = data[0]; cap_pe = pe[0]; cap_fe = fe[0];
        check("8n1_seen", vld[0], 1'b1);
        check("8n1_latency_window", (cyc >= 2964 && cyc <= 2972), 1'b1);
        check("8n1_data", cap_data, 8'h55);
        check("8n1_errs", {cap_pe, cap_fe}, 2'b00);
        @(negedge clk);
        check("8n1_pulse", vld[0], 1'b0);
      end
    join
    ready[0] = 1'b0;
    tick(20);
    check("8n1_busy_after", busy[0], 1'b0);

    // 100-cycle glitch: rejected at the START sample point
    rxd[0] = 1'b0;
    tick(100);
    rxd[0] = 1'b1;
    tick(58);
    check("glitch_busy_before", busy[0], 1'b1);
    tick(2);
    check("glitch_busy_after", busy[0], 1'b0);
    tick(400);
    check("glitch_no_push", vld[0], 1'b0);
    check("glitch_no_flags", {pe[0], fe[0]}, 2'b00);

    // Even parity, 0xA3: correct parity bit is 0
    send_frame(1, 8'hA3, 1, 1'b1, 1'b1, 1);
    tick(4);
    check_head("par_bad", 1, 8'hA3, 1'b1, 1'b0);
    pop_one(1);
    send_frame(1, 8'hA3, 0, 1'b1, 1'b1, 1);
    tick(4);
    check_head("par_ok", 1, 8'hA3, 1'b0, 1'b0);
    pop_one(1);
    check("par_drained", vld[1], 1'b0);

    // Stuck-low line: one frame with frame error, then no restart while low
    rxd[1] = 1'b0;
    tick(16 * 15);
    check_head("break", 1, 8'h00, 1'b0, 1'b1);
    pop_one(1);
    tick(16 * 5);
    check("break_no_restart", vld[1], 1'b0);
    rxd[1] = 1'b1;
    tick(40);
    check("break_release", vld[1], 1'b0);

    // Two stop bits, second one low
    send_frame(2, 8'h3C, -1, 1'b1, 1'b0, 2);
    tick(4);
    check_head("stop2_bad", 2, 8'h3C, 1'b0, 1'b1);
    pop_one(2);
    tick(20);
    send_frame(2, 8'h11, -1, 1'b1, 1'b1, 2);
    tick(4);
    check_head("stop2_ok", 2, 8'h11, 1'b0, 1'b0);
    pop_one(2);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), -1, 1'b1, 1'b1, 1);
      if (i <= 4) exp_q.push_back(8'(i));
    end
    tick(4);
    check_head("ovr_head", 0, 8'h01, 1'b0, 1'b0);
    check("ovr_set", ovr[0], 1'b1);
    while (exp_q.size() > 0) begin
      check("drain_valid", vld[0], 1'b1);
      check("drain_data", data[0], exp_q.pop_front());
      pop_one(0);
    end
    check("drain_empty", vld[0], 1'b0);
    pop_one(0);
    check("pop_empty_valid", vld[0], 1'b0);
    check("pop_empty_data", data[0], 8'h00);
    check("ovr_sticky", ovr[0], 1'b1);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    check("ovr_cleared", ovr[0], 1'b0);

    // Reset with a word held and a frame in flight
    send_frame(0, 8'h42, -1, 1'b1, 1'b1, 1);
    tick(4);
    check("pre_rst_valid", vld[0], 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    rst = 1'b1;
    tick(2);
    check("mid_rst_valid", vld[0], 1'b0);
    check("mid_rst_data", data[0], 8'h00);
    check("mid_rst_busy", busy[0], 1'b0);
    check("mid_rst_errs", {pe[0], fe[0], ovr[0]}, 3'b000);
    rxd[0] = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(400);
    check("post_rst_idle", {vld[0], busy[0]}, 2'b00);
    send_frame(0, 8'h9A, -1, 1'b1, 1'b1, 1);
    tick(4);
    check_head("post_rst", 0, 8'h9A, 1'b0, 1'b0);
    pop_one(0);
    check("post_rst_only_one", vld[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver. Generalises the fixed 8N1 receiver in three ways:
  - configurable data width, parity and stop-bit count;
  - start-bit glitch rejection;
  - per-word parity and framing error flags, plus a sticky overrun flag.
- Received words are buffered in a small show-ahead FIFO with a valid/ready consumer handshake.
- Sits between the board RX pin and the CPU's MMIO/UART register block.

Parameters:
- CLK_FREQ, 40_000_000: system clock frequency in Hz.
- UART_BPS, 128000: baud rate. Derived BPS_CNT = CLK_FREQ/UART_BPS, integer divide.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries in the receive FIFO. Power of two, at least 2.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- uart_rxd  in  1  asynchronous serial input; idles high.
- rx_data  out  DATA_BITS  data of the FIFO head entry.
- rx_parity_err  out  1  parity error flag of the head entry.
- rx_frame_err  out  1  framing error flag of the head entry.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head entry.
- rx_overrun  out  1  sticky: a completed word was dropped because the FIFO was full.
- clr_err  in  1  clears rx_overrun.
- rx_busy  out  1  a frame is being received (FSM not in IDLE).

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - FSM goes to IDLE; FIFO is emptied; all counters cleared.
  - Outputs: rx_valid=0, rx_data=0, both error outputs 0, rx_overrun=0, rx_busy=0.
  - The two synchroniser flops load 1 so reset release never creates a false start.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Input path:
  - uart_rxd passes through a 2-flop synchroniser; rxd_s is the second flop.
  - Start edge = previous rxd_s high and current rxd_s low.
- Bit timer:
  - clk_cnt runs 0..BPS_CNT-1, wrapping to 0; it is cleared on entry to START.
  - The sample point is clk_cnt == BPS_CNT/2.
  - The bit index advances on the wrap.
- FSM states:
  - IDLE: on a start edge go to START.
  - START: at the sample point, if rxd_s==1 (glitch) return to IDLE with no push and no flags; otherwise continue. On the wrap go to DATA.
  - DATA: sample DATA_BITS bits, LSB first, into a shift register. After the last bit's wrap go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample the parity bit.
    - Odd parity: XOR of data bits and parity bit must be 1.
    - Even parity: that XOR must be 0.
    - Mismatch sets the word's parity_err.
  - STOP: sample each of STOP_BITS stop bits; any stop sample equal to 0 sets frame_err.
    - On the final stop bit's sample point (not its wrap), push {frame_err, parity_err, data} and go to IDLE in the same cycle. This gives half a bit of margin for the next start edge.
- Break or stuck-low line:
  - Frame is pushed with frame_err=1.
  - No new frame starts until rxd_s returns high and falls again.
- FIFO:
  - Show-ahead: rx_valid = !empty; rx_data and both error flags reflect the head entry.
  - Pop occurs when rx_valid && rx_ready.
  - Push-to-rx_valid latency is 1 cycle (registered write; rx_valid rises on the next edge).
  - rx_data is 0 when empty.
- Boundary conditions:
  - Push while full without a pop: the word is dropped, FIFO contents are unchanged, and rx_overrun is set on the next edge.
  - Push while full with a same-cycle pop: both happen; the word is not dropped and no overrun.
  - Pop while empty: ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- rx_overrun: once set, it holds until clr_err=1. If set and clr_err occur in the same cycle, set wins.
- rx_busy: 1 in every state except IDLE.

Test Plan:
- Defaults (BPS_CNT=312), 8N1 frame 0x55, rx_ready=1 -> one word 0x55, no error flags; rx_valid pulses 1 cycle, rising ~(9*312+156+3) cycles after the falling edge; rx_busy low afterwards.
- 100-cycle low glitch on an idle line -> START rejects it; no push, no flags, rx_busy returns to 0 at sample point +1.
- PARITY=2, frame 0xA3 with parity bit 1 (correct is 0) -> rx_data 0xA3 with rx_parity_err=1. Same frame with parity bit 0 -> rx_parity_err=0.
- STOP_BITS=2, 8N1 frame 0x3C with second stop bit driven 0 -> rx_data 0x3C, rx_frame_err=1. A following valid frame 0x11 -> rx_frame_err=0.
- rx_ready=0, five back-to-back frames 0x01..0x05 -> rx_valid=1, head 0x01, rx_overrun=1 after the 5th. Then rx_ready=1 drains 0x01,0x02,0x03,0x04 only; clr_err pulse -> rx_overrun=0.
- sys_rst asserted mid-DATA of frame 0x77, released, then frame 0x9A -> only 0x9A appears; all outputs 0 during reset.
